// File: rtl/floo_multi_id_meta_buffer_pkg.sv
// Shared definitions for the multi-ID meta buffer.
// Response/request ID layout: IDs 0..NumIds-1 address the ordered non-atomic
// queues; IDs NumIds..NumIds+MaxAtomicTxns-1 address the unique atomic slots.
package floo_multi_id_meta_buffer_pkg;

    // Reservation state of the atomic slot allocator.
    typedef enum logic {
        SLOT_UNLOCKED = 1'b0,
        SLOT_LOCKED   = 1'b1
    } slot_lock_e;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/floo_atop_slot_alloc.sv
// Atomic slot allocator: holds one meta entry per unique atomic ID, reserves
// the lowest free slot for a waiting atomic and keeps that reservation stable
// until the request handshakes.
//
// Handshake: the atomic is accepted in a cycle where alloc_valid_i and
// alloc_ready_o are both high; alloc_ready_o is high only while a slot is
// reserved, and the reserved index never changes while it is held.
module floo_atop_slot_alloc
    import floo_multi_id_meta_buffer_pkg::*;
#(
    parameter int unsigned NumSlots = 2,
    parameter type         buf_t    = logic,
    parameter int unsigned SlotW    = idx_width(NumSlots)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_valid_i,
    input  buf_t                alloc_buf_i,
    output logic                alloc_ready_o,
    output logic [SlotW-1:0]    alloc_idx_o,
    input  logic                free_i,
    input  logic [SlotW-1:0]    free_idx_i,
    output logic [NumSlots-1:0] occupied_o,
    output buf_t                slot_buf_o [NumSlots],
    output slot_lock_e          lock_state_o
);

    slot_lock_e          lock_q, lock_d;
    logic [SlotW-1:0]    idx_q, idx_d;
    logic [NumSlots-1:0] occ_q, occ_d;
    buf_t                buf_q [NumSlots];
    buf_t                buf_d [NumSlots];
    logic                any_free;
    logic [SlotW-1:0]    first_free;

    // Lowest-index free slot, taken from the registered mask so a slot freed
    // this cycle is only offered from the next cycle on.
    always_comb begin
        any_free   = 1'b0;
        first_free = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                any_free   = 1'b1;
                first_free = SlotW'(i);
            end
        end
    end

    // Reservation FSM plus slot fill/free bookkeeping.
    always_comb begin
        lock_d = lock_q;
        idx_d  = idx_q;
        occ_d  = occ_q;
        buf_d  = buf_q;
        // A reserved slot is never occupied, so a free and a fill never collide.
        if (free_i) begin
            occ_d[free_idx_i] = 1'b0;
        end
        case (lock_q)
            SLOT_UNLOCKED: begin
                if (alloc_valid_i && any_free) begin
                    lock_d = SLOT_LOCKED;
                    idx_d  = first_free;
                end
            end
            SLOT_LOCKED: begin
                if (alloc_valid_i) begin
                    lock_d        = SLOT_UNLOCKED;
                    occ_d[idx_q]  = 1'b1;
                    buf_d[idx_q]  = alloc_buf_i;
                end
            end
            default: lock_d = SLOT_UNLOCKED;
        endcase
    end

    // State registers; reset frees every slot and drops any reservation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= SLOT_UNLOCKED;
            idx_q  <= '0;
            occ_q  <= '0;
            buf_q  <= '{default: '0};
        end else begin
            lock_q <= lock_d;
            idx_q  <= idx_d;
            occ_q  <= occ_d;
            buf_q  <= buf_d;
        end
    end

    assign alloc_ready_o = (lock_q == SLOT_LOCKED);
    assign alloc_idx_o   = idx_q;
    assign occupied_o    = occ_q;
    assign slot_buf_o    = buf_q;
    assign lock_state_o  = lock_q;

endmodule

// File: rtl/floo_multi_id_meta_buffer.sv
// Multi-ID meta buffer: stores request meta per outgoing ID and returns it
// combinationally when the matching response arrives. Non-atomics share one
// ordered FIFO per ID; atomics each get a unique slot ID.
//
// Handshake: a request is accepted on a cycle with req_valid_i && req_ready_o;
// req_id_o is valid in that same cycle. A response pop takes effect at the
// clock edge ending the cycle in which rsp_pop_i is high.
module floo_multi_id_meta_buffer
    import floo_multi_id_meta_buffer_pkg::*;
#(
    parameter int unsigned NumIds        = 4,
    parameter int unsigned MaxTxnsPerId  = 8,
    parameter bit          AtopSupport   = 1'b1,
    parameter int unsigned MaxAtomicTxns = 2,
    parameter type         buf_t         = logic,
    parameter type         id_t          = logic [2:0],
    parameter type         cnt_t         = logic [7:0]
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       test_enable_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  buf_t       req_buf_i,
    input  logic       req_is_atop_i,
    input  id_t        req_queue_i,
    output id_t        req_id_o,
    input  logic       rsp_pop_i,
    input  id_t        rsp_id_i,
    output buf_t       rsp_buf_o,
    output logic       rsp_err_o,
    output cnt_t       outstanding_o,
    output logic       idle_o,
    output slot_lock_e lock_state_o
);

    localparam int unsigned PtrW  = idx_width(MaxTxnsPerId);
    localparam int unsigned FillW = $clog2(MaxTxnsPerId + 1);
    localparam int unsigned SlotW = idx_width(MaxAtomicTxns);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTxnsPerId - 1)) ? '0 : p + PtrW'(1);
    endfunction

    buf_t              mem_q [NumIds][MaxTxnsPerId];
    buf_t              mem_d [NumIds][MaxTxnsPerId];
    logic [PtrW-1:0]   wr_ptr_q [NumIds];
    logic [PtrW-1:0]   wr_ptr_d [NumIds];
    logic [PtrW-1:0]   rd_ptr_q [NumIds];
    logic [PtrW-1:0]   rd_ptr_d [NumIds];
    logic [FillW-1:0]  fill_q [NumIds];
    logic [FillW-1:0]  fill_d [NumIds];
    cnt_t              outstanding_q, outstanding_d;
    logic              err_q, err_d;

    logic [NumIds-1:0]        q_push, q_pop;
    logic                     hit, pop_ok, accept;
    logic                     slot_ready, slot_free;
    logic [SlotW-1:0]         slot_idx, slot_free_idx;
    logic [MaxAtomicTxns-1:0] slot_occ;
    buf_t                     slot_buf [MaxAtomicTxns];

    // No clock gating or scan-sensitive storage here, so test mode has no effect.
    logic unused_test_enable;
    assign unused_test_enable = test_enable_i;

    floo_atop_slot_alloc #(
        .NumSlots (MaxAtomicTxns),
        .buf_t    (buf_t),
        .SlotW    (SlotW)
    ) i_slot_alloc (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_valid_i (req_valid_i && req_is_atop_i && AtopSupport),
        .alloc_buf_i   (req_buf_i),
        .alloc_ready_o (slot_ready),
        .alloc_idx_o   (slot_idx),
        .free_i        (slot_free),
        .free_idx_i    (slot_free_idx),
        .occupied_o    (slot_occ),
        .slot_buf_o    (slot_buf),
        .lock_state_o  (lock_state_o)
    );

    // Request side: route to the target queue or the reserved atomic slot.
    always_comb begin
        q_push      = '0;
        req_ready_o = 1'b0;
        req_id_o    = req_queue_i;
        if (req_is_atop_i) begin
            req_ready_o = AtopSupport && slot_ready;
            req_id_o    = id_t'(NumIds) + id_t'(slot_idx);
        end else begin
            // Out-of-range queue numbers match no queue and stay unready.
            for (int q = 0; q < NumIds; q++) begin
                if (req_queue_i == id_t'(q)) begin
                    req_ready_o = (fill_q[q] != FillW'(MaxTxnsPerId));
                    q_push[q]   = req_valid_i && req_ready_o;
                end
            end
        end
        accept = req_valid_i && req_ready_o;
    end

    // Response side: zero-latency lookup and pop qualification.
    always_comb begin
        rsp_buf_o     = '0;
        hit           = 1'b0;
        q_pop         = '0;
        slot_free     = 1'b0;
        slot_free_idx = '0;
        for (int q = 0; q < NumIds; q++) begin
            if (rsp_id_i == id_t'(q)) begin
                hit = (fill_q[q] != '0);
                if (hit) rsp_buf_o = mem_q[q][rd_ptr_q[q]];
                q_pop[q] = rsp_pop_i && hit;
            end
        end
        for (int s = 0; s < MaxAtomicTxns; s++) begin
            if (rsp_id_i == id_t'(NumIds + s)) begin
                hit = slot_occ[s];
                if (hit) rsp_buf_o = slot_buf[s];
                slot_free     = rsp_pop_i && hit;
                slot_free_idx = SlotW'(s);
            end
        end
        pop_ok = rsp_pop_i && hit;
    end

    // Queue storage, outstanding count and sticky error next-state.
    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fill_d        = fill_q;
        outstanding_d = outstanding_q;
        err_d         = err_q | (rsp_pop_i && !hit);
        for (int q = 0; q < NumIds; q++) begin
            if (q_push[q]) begin
                mem_d[q][wr_ptr_q[q]] = req_buf_i;
                wr_ptr_d[q]           = ptr_inc(wr_ptr_q[q]);
            end
            if (q_pop[q]) begin
                rd_ptr_d[q] = ptr_inc(rd_ptr_q[q]);
            end
            // Push and pop together leave the occupancy unchanged.
            if (q_push[q] && !q_pop[q]) begin
                fill_d[q] = fill_q[q] + FillW'(1);
            end else if (!q_push[q] && q_pop[q]) begin
                fill_d[q] = fill_q[q] - FillW'(1);
            end
        end
        if (accept && !pop_ok && (outstanding_q != '1)) begin
            outstanding_d = outstanding_q + cnt_t'(1);
        end else if (!accept && pop_ok && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - cnt_t'(1);
        end
    end

    // State registers; reset discards every stored entry and the error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '{default: '0};
            rd_ptr_q      <= '{default: '0};
            fill_q        <= '{default: '0};
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign rsp_err_o     = err_q;
    assign outstanding_o = outstanding_q;
    assign idle_o        = (outstanding_q == '0);

    // Atomics must never be presented when atomic support is compiled out.
    atop_unsupported_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(req_valid_i && req_is_atop_i && !AtopSupport));

endmodule

// File: tb/tb_floo_multi_id_meta_buffer.sv
// Directed scoreboard bench for floo_multi_id_meta_buffer (4 IDs, depth 2,
// 2 atomic slots, 8-bit meta).
module tb_floo_multi_id_meta_buffer;
    import floo_multi_id_meta_buffer_pkg::*;

    logic       clk, rst_n, test_enable;
    logic       req_valid, req_ready, req_is_atop;
    logic [7:0] req_buf, rsp_buf, outstanding;
    logic [2:0] req_queue, req_id, rsp_id;
    logic       rsp_pop, rsp_err, idle;
    slot_lock_e lock_state;
    logic       pop_chk;

    int checks, failures;
    logic [7:0] exp_buf_q[$];
    logic [2:0] exp_id_q[$];
    logic [7:0] eb;
    logic [2:0] ei;

    floo_multi_id_meta_buffer #(
        .NumIds        (4),
        .MaxTxnsPerId  (2),
        .AtopSupport   (1'b1),
        .MaxAtomicTxns (2),
        .buf_t         (logic [7:0]),
        .id_t          (logic [2:0]),
        .cnt_t         (logic [7:0])
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .test_enable_i (test_enable),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_buf_i     (req_buf),
        .req_is_atop_i (req_is_atop),
        .req_queue_i   (req_queue),
        .req_id_o      (req_id),
        .rsp_pop_i     (rsp_pop),
        .rsp_id_i      (rsp_id),
        .rsp_buf_o     (rsp_buf),
        .rsp_err_o     (rsp_err),
        .outstanding_o (outstanding),
        .idle_o        (idle),
        .lock_state_o  (lock_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_is_atop = 1'b0;
        req_queue   = '0;
        req_buf     = '0;
        rsp_pop     = 1'b0;
        rsp_id      = '0;
        pop_chk     = 1'b0;
    endtask

    task automatic send_req(input logic atop, input int q, input logic [7:0] d,
                            input int exp_id, input string name);
        bit ok;
        ok = 1'b0;
        exp_id_q.push_back(3'(exp_id));
        req_valid   = 1'b1;
        req_is_atop = atop;
        req_queue   = 3'(q);
        req_buf     = d;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: no handshake within 8 cycles, ready=%0d required 1", name, req_ready);
            void'(exp_id_q.pop_back());
        end
        step();
        req_valid   = 1'b0;
        req_is_atop = 1'b0;
    endtask

    task automatic pop_id(input int id, input logic [7:0] d);
        exp_buf_q.push_back(d);
        rsp_pop = 1'b1;
        rsp_id  = 3'(id);
        pop_chk = 1'b1;
        step();
        rsp_pop = 1'b0;
        pop_chk = 1'b0;
    endtask

    task automatic bad_pop(input int id);
        rsp_pop = 1'b1;
        rsp_id  = 3'(id);
        pop_chk = 1'b0;
        step();
        rsp_pop = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) begin
                checks++;
                if (exp_id_q.size() == 0) begin
                    failures++;
                    $display("FAIL mon_req_id: unexpected handshake id=%0d, none required", req_id);
                end else begin
                    ei = exp_id_q.pop_front();
                    if (req_id !== ei) begin
                        failures++;
                        $display("FAIL mon_req_id: got %0d expected %0d", req_id, ei);
                    end
                end
            end
            if (rsp_pop && pop_chk) begin
                checks++;
                if (exp_buf_q.size() == 0) begin
                    failures++;
                    $display("FAIL mon_rsp_buf: unexpected pop buf=%0h, none required", rsp_buf);
                end else begin
                    eb = exp_buf_q.pop_front();
                    if (rsp_buf !== eb) begin
                        failures++;
                        $display("FAIL mon_rsp_buf: got %0h expected %0h", rsp_buf, eb);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks      = 0;
        failures    = 0;
        test_enable = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_outstanding", outstanding, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", rsp_err, 0);
        chk("rst_lock", lock_state, SLOT_UNLOCKED);
        chk("rst_ready_q0", req_ready, 1);

        // Queue full on q1 does not block q2; FIFO order on q1
        send_req(1'b0, 1, 8'hA1, 1, "push_q1_a");
        send_req(1'b0, 1, 8'hB2, 1, "push_q1_b");
        req_valid = 1'b1; req_queue = 3'd1; req_buf = 8'hEE;
        @(negedge clk);
        chk("q1_full_ready", req_ready, 0);
        req_valid = 1'b0;
        step();
        send_req(1'b0, 2, 8'hC3, 2, "push_q2");
        chk("outstanding_3", outstanding, 3);
        pop_id(1, 8'hA1);
        pop_id(1, 8'hB2);
        pop_id(2, 8'hC3);
        chk("outstanding_drained", outstanding, 0);
        chk("idle_drained", idle, 1);

        // Same-cycle push and pop on q0 at occupancy 1
        send_req(1'b0, 0, 8'h11, 0, "push_q0_w");
        exp_id_q.push_back(3'd0);
        exp_buf_q.push_back(8'h11);
        req_valid = 1'b1; req_is_atop = 1'b0; req_queue = 3'd0; req_buf = 8'h22;
        rsp_pop = 1'b1; rsp_id = 3'd0; pop_chk = 1'b1;
        step();
        idle_inputs();
        chk("pushpop_occupancy", outstanding, 1);
        pop_id(0, 8'h22);
        chk("pushpop_drained", outstanding, 0);

        // Atomics: IDs 4 then 5, third stalls until slot 0 is freed
        send_req(1'b1, 0, 8'hD4, 4, "atop_first");
        send_req(1'b1, 0, 8'hE5, 5, "atop_second");
        chk("atop_outstanding_2", outstanding, 2);
        req_valid = 1'b1; req_is_atop = 1'b1; req_buf = 8'hF6;
        repeat (2) begin
            @(negedge clk);
            chk("atop_third_stalls", req_ready, 0);
        end
        step();
        exp_id_q.push_back(3'd4);
        exp_buf_q.push_back(8'hD4);
        rsp_pop = 1'b1; rsp_id = 3'd4; pop_chk = 1'b1;
        @(negedge clk);
        chk("atop_no_same_cycle_reuse", req_ready, 0);
        step();
        rsp_pop = 1'b0; pop_chk = 1'b0;
        begin
            bit ok;
            ok = 1'b0;
            for (int n = 0; n < 5; n++) begin
                @(negedge clk);
                if (req_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL atop_third_reuse: ready=%0d required 1 within 5 cycles", req_ready);
                void'(exp_id_q.pop_back());
            end
        end
        step();
        idle_inputs();
        chk("atop_outstanding_after_reuse", outstanding, 2);

        // Reservation stays locked on slot 1 while slot 0 is freed
        pop_id(5, 8'hE5);
        exp_id_q.push_back(3'd5);
        req_valid = 1'b1; req_is_atop = 1'b1; req_buf = 8'h77;
        exp_buf_q.push_back(8'hF6);
        rsp_pop = 1'b1; rsp_id = 3'd4; pop_chk = 1'b1;
        @(negedge clk);
        chk("lock_first_cycle_ready", req_ready, 0);
        step();
        rsp_pop = 1'b0; pop_chk = 1'b0;
        @(negedge clk);
        chk("lock_state_locked", lock_state, SLOT_LOCKED);
        chk("lock_id_stable", req_id, 5);
        chk("lock_ready", req_ready, 1);
        step();
        idle_inputs();
        chk("lock_outstanding", outstanding, 1);
        pop_id(5, 8'h77);
        chk("lock_drained", outstanding, 0);

        // Error pops: empty queue, out-of-range ID, free slot
        send_req(1'b0, 2, 8'h33, 2, "push_q2_err");
        chk("err_before", rsp_err, 0);
        bad_pop(3);
        chk("err_empty_queue", rsp_err, 1);
        chk("err_outstanding_q3", outstanding, 1);
        bad_pop(6);
        chk("err_outstanding_range", outstanding, 1);
        bad_pop(4);
        chk("err_outstanding_slot", outstanding, 1);
        repeat (3) step();
        chk("err_sticky", rsp_err, 1);
        pop_id(2, 8'h33);
        chk("err_drained", outstanding, 0);

        // Fill every queue to depth, check each full, drain in reverse ID order
        for (int q = 0; q < 4; q++) begin
            send_req(1'b0, q, 8'h40 + 8'(q), q, "fill_first");
            send_req(1'b0, q, 8'h50 + 8'(q), q, "fill_second");
        end
        for (int q = 0; q < 4; q++) begin
            req_valid = 1'b1; req_queue = 3'(q);
            @(negedge clk);
            chk("all_full_ready", req_ready, 0);
            step();
        end
        idle_inputs();
        chk("all_full_outstanding", outstanding, 8);
        for (int q = 3; q >= 0; q--) begin
            pop_id(q, 8'h40 + 8'(q));
            pop_id(q, 8'h50 + 8'(q));
        end
        chk("all_full_drained", outstanding, 0);

        // Reset mid-operation after 5 pushes and a held reservation
        send_req(1'b0, 0, 8'h61, 0, "rst_push0");
        send_req(1'b0, 0, 8'h62, 0, "rst_push1");
        send_req(1'b0, 1, 8'h63, 1, "rst_push2");
        send_req(1'b0, 2, 8'h64, 2, "rst_push3");
        send_req(1'b0, 3, 8'h65, 3, "rst_push4");
        chk("pre_rst_outstanding", outstanding, 5);
        chk("pre_rst_idle", idle, 0);
        req_valid = 1'b1; req_is_atop = 1'b1; req_buf = 8'h99;
        step();
        req_valid = 1'b0; req_is_atop = 1'b0;
        chk("pre_rst_locked", lock_state, SLOT_LOCKED);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outstanding", outstanding, 0);
        step();
        rst_n = 1'b1;
        chk("post_rst_idle", idle, 1);
        chk("post_rst_err", rsp_err, 0);
        chk("post_rst_lock", lock_state, SLOT_UNLOCKED);
        for (int q = 0; q < 4; q++) begin
            req_queue = 3'(q);
            #1;
            chk("post_rst_ready", req_ready, 1);
        end
        req_queue = '0;
        bad_pop(0);
        chk("post_rst_no_survivor", rsp_err, 1);
        chk("post_rst_outstanding", outstanding, 0);

        step();
        chk("exp_id_q_drained", exp_id_q.size(), 0);
        chk("exp_buf_q_drained", exp_buf_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
